dcache_refill_ctrl: RTL and testbench
=====================================

Name: dcache_refill_ctrl

Overview:
- Miss/refill controller directly downstream of the data cache wrapper (cache signals `hit`/`DataMemRead`, CPU drives A/WD/MemWrite).
- On a read miss: stalls the CPU, fetches the whole line word-by-word from backing memory over a valid/ready request + valid response interface, writes each word into the cache data array, then pulses a tag/valid update.
- Also serialises write-through stores to memory.

Parameters:
- ADDR_W, 32, address width in bits
- DATA_W, 32, word width in bits
- LINE_WORDS, 4, words per cache line (power of two, 2..16)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- miss_valid  in  1  cache read miss on current access
- miss_addr  in  ADDR_W  byte address of missing access
- wr_req  in  1  CPU store (MemWrite) to be written through
- wr_addr  in  ADDR_W  store byte address
- wr_data  in  DATA_W  store data
- stall  out  1  CPU pipeline hold
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_addr  out  ADDR_W  word-aligned request address
- mem_req_wdata  out  DATA_W  write data
- mem_rsp_valid  in  1  read data valid (one per read)
- mem_rsp_data  in  DATA_W  read data
- fill_we  out  1  write one word into cache data array
- fill_addr  out  ADDR_W  byte address of filled word
- fill_data  out  DATA_W  filled word
- fill_done  out  1  one-cycle pulse: write tag + set valid for line
- fill_line_addr  out  ADDR_W  line base address (low log2(LINE_WORDS)+2 bits zero)

Behaviour:
- Reset (async, any state): state IDLE, beat counter 0, all outputs 0 (stall, mem_req_valid, mem_req_we, fill_we, fill_done, all address/data buses).
- States: IDLE, WRITE, REQ, WAIT, DONE.
- IDLE:
  - wr_req=1 → latch wr_addr/wr_data, go WRITE (stores take priority when wr_req and miss_valid are both high).
  - Else miss_valid=1 → latch line base = miss_addr with offset bits cleared, beat=0, go REQ.
  - stall = wr_req | miss_valid (combinational) in IDLE; stall=1 in every other state.
- WRITE:
  - mem_req_valid=1, we=1; addr/wdata held stable until mem_req_ready.
  - On handshake → IDLE. No response expected for writes.
- REQ:
  - mem_req_valid=1, we=0, addr = base + beat*4.
  - Held stable until mem_req_ready; on handshake → WAIT.
- WAIT:
  - On mem_rsp_valid: fill_we=1 for that cycle, fill_addr = request address, fill_data = mem_rsp_data.
  - If beat == LINE_WORDS-1 → DONE; else beat+1, → REQ.
  - Exactly one outstanding read at a time.
- DONE: fill_done=1 for one cycle, fill_line_addr = base; → IDLE. The cache re-looks up the same access in the next cycle and hits.
- Minimum miss latency (ready and response each 1 cycle): 2*LINE_WORDS + 1 cycles of stall.
- Beat counter width is log2(LINE_WORDS); offset arithmetic wraps modulo the line, with no carry into the tag.
- mem_rsp_valid outside WAIT is ignored (covers stale responses after reset mid-refill).
- Inputs are not sampled outside IDLE; a store or miss arriving while busy is held by stall and re-presented.
- Reset mid-refill: line is never marked valid (fill_done not issued); partially written data words are harmless.

Optional Feature:
- Macro: DCACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Beat order starts at the miss word offset and wraps modulo LINE_WORDS.
  - Extra output `crit_ready` pulses with the first fill_we, so the CPU can observe the critical word early.
  - stall still holds until DONE.
- Undefined: order is always offset 0..LINE_WORDS-1; `crit_ready` port absent.

Decomposition:
- Shared package dcache_pkg:
  - state enum (IDLE, WRITE, REQ, WAIT, DONE)
  - LINE_WORDS default
  - OFFSET_W = log2(LINE_WORDS)
  - BYTE_OFF = 2
  - function line_base(addr)
- No sub-module: a single FSM plus beat counter is natural.

Test Plan:
- Miss at 0x0000_0048, ready/rsp immediate → reads 0x40, 0x44, 0x48, 0x4C in order; four fill_we pulses; fill_done with fill_line_addr=0x40; stall high for exactly 9 cycles.
- Same miss with DCACHE_CRITICAL_WORD_FIRST_EN → order 0x48, 0x4C, 0x40, 0x44; crit_ready coincides with the 0x48 fill.
- wr_req (0x100, 0xDEADBEEF) and miss_valid (0x200) in the same cycle; mem_req_ready held low 3 cycles → write request held stable, issued first with we=1; refill of 0x200 follows.
- Responses delayed 5 cycles and mem_req_ready toggling → no extra requests, addresses stable while waiting, fill data equals the memory model's contents.
- rst_n low during WAIT of beat 2 → all outputs 0 immediately; a late mem_rsp_valid is ignored; no fill_done; a new miss afterwards completes normally.
- Back-to-back misses 0x40 then 0x80 → second refill starts the cycle after returning to IDLE; both fill_done pulses carry the correct line addresses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the data-cache refill controller.
// Shared by the default build and the DCACHE_CRITICAL_WORD_FIRST_EN build.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    REQ,
    WAIT,
    DONE
  } state_e;

  localparam int LINE_WORDS_DEFAULT = 4;
  localparam int OFFSET_W           = $clog2(LINE_WORDS_DEFAULT);
  localparam int BYTE_OFF           = 2;

  // Clears the word-offset and byte-offset bits of an address.
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int off_w);
    logic [63:0] mask;
    mask = (64'd1 << (off_w + BYTE_OFF)) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss/refill controller with write-through store serialisation.
// DCACHE_CRITICAL_WORD_FIRST_EN: refill starts at the missing word and adds crit_ready.
module dcache_refill_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_done,
  output logic [ADDR_W-1:0] fill_line_addr
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  ,
  output logic              crit_ready
`endif
);

  localparam int               OFF_W     = $clog2(LINE_WORDS);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  state_e            state_q;
  logic [OFF_W-1:0]  beat_q;
  logic [ADDR_W-1:0] base_q;
  logic              mem_req_valid_q;
  logic              mem_req_we_q;
  logic [ADDR_W-1:0] mem_req_addr_q;
  logic [DATA_W-1:0] mem_req_wdata_q;
  logic              fill_done_q;
  logic [ADDR_W-1:0] fill_line_addr_q;

  logic [OFF_W-1:0]  start_off;
  logic [OFF_W-1:0]  miss_off;
  logic [OFF_W-1:0]  next_off;
  logic [ADDR_W-1:0] miss_base;

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  logic [OFF_W-1:0] start_off_q;
  assign start_off = start_off_q;
  assign miss_off  = miss_addr[OFF_W+BYTE_OFF-1:BYTE_OFF];
`else
  assign start_off = '0;
  assign miss_off  = '0;
`endif

  // Offset sum wraps inside the line so the tag bits never change.
  assign next_off  = start_off + beat_q + OFF_W'(1);
  assign miss_base = ADDR_W'(line_base(64'(miss_addr), OFF_W));

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [OFF_W-1:0]  off);
    return base | (ADDR_W'(off) << BYTE_OFF);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      beat_q           <= '0;
      base_q           <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_req_we_q     <= 1'b0;
      mem_req_addr_q   <= '0;
      mem_req_wdata_q  <= '0;
      fill_done_q      <= 1'b0;
      fill_line_addr_q <= '0;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
      start_off_q      <= '0;
`endif
    end else begin
      fill_done_q      <= 1'b0;
      fill_line_addr_q <= '0;
      case (state_q)
        IDLE: begin
          if (wr_req) begin
            state_q         <= WRITE;
            mem_req_valid_q <= 1'b1;
            mem_req_we_q    <= 1'b1;
            mem_req_addr_q  <= wr_addr & ~ADDR_W'(3);
            mem_req_wdata_q <= wr_data;
          end else if (miss_valid) begin
            state_q         <= REQ;
            base_q          <= miss_base;
            beat_q          <= '0;
            mem_req_valid_q <= 1'b1;
            mem_req_we_q    <= 1'b0;
            mem_req_addr_q  <= word_addr(miss_base, miss_off);
            mem_req_wdata_q <= '0;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
            start_off_q     <= miss_off;
`endif
          end
        end
        WRITE: begin
          if (mem_req_ready) begin
            state_q         <= IDLE;
            mem_req_valid_q <= 1'b0;
            mem_req_we_q    <= 1'b0;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state_q         <= WAIT;
            mem_req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (beat_q == LAST_BEAT) begin
              state_q          <= DONE;
              fill_done_q      <= 1'b1;
              fill_line_addr_q <= base_q;
            end else begin
              state_q         <= REQ;
              beat_q          <= beat_q + OFF_W'(1);
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= word_addr(base_q, next_off);
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // A held-off store or miss must freeze the CPU even before it is accepted.
  assign stall          = (state_q == IDLE) ? (wr_req | miss_valid) : 1'b1;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_we     = mem_req_we_q;
  assign mem_req_addr   = mem_req_addr_q;
  assign mem_req_wdata  = mem_req_wdata_q;
  assign fill_we        = (state_q == WAIT) && mem_rsp_valid;
  assign fill_addr      = fill_we ? mem_req_addr_q : '0;
  assign fill_data      = fill_we ? mem_rsp_data : '0;
  assign fill_done      = fill_done_q;
  assign fill_line_addr = fill_line_addr_q;

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  assign crit_ready = fill_we && (beat_q == '0);
`endif

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Scoreboard bench for dcache_refill_ctrl: a memory model answers requests,
// expected requests/fills/line completions are queued when stimulus is driven.
module tb_dcache_refill_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          first;
  } fill_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          miss_valid;
  logic [AW-1:0] miss_addr;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          stall;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic          fill_we;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;
  logic          fill_done;
  logic [AW-1:0] fill_line_addr;
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  logic          crit_ready;
`endif

  int total  = 0;
  int passed = 0;

  req_t        req_q[$];
  fill_t       fill_q[$];
  logic [31:0] line_q[$];

  int rd_hs    = 0;
  int wr_hs    = 0;
  int done_cnt = 0;

  int ready_delay  = 0;
  bit ready_toggle = 1'b0;
  int rsp_delay    = 0;

  always #5 clk = ~clk;

  dcache_refill_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .LINE_WORDS(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .miss_valid(miss_valid),
    .miss_addr(miss_addr),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .stall(stall),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .fill_we(fill_we),
    .fill_addr(fill_addr),
    .fill_data(fill_data),
    .fill_done(fill_done),
    .fill_line_addr(fill_line_addr)
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
    , .crit_ready(crit_ready)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Queue the reads, fills and line completion a refill of addr a should produce.
  task automatic push_miss(input logic [31:0] a, input int nreq, input int nfill, input bit with_done);
    logic [31:0] base;
    logic [31:0] wa;
    int start;
    base  = a & ~32'(LW * 4 - 1);
    start = CWF ? int'((a >> 2) % LW) : 0;
    for (int i = 0; i < nreq; i++) begin
      wa = base | 32'(((start + i) % LW) * 4);
      req_q.push_back('{we: 1'b0, addr: wa, wdata: 32'h0});
    end
    for (int i = 0; i < nfill; i++) begin
      wa = base | 32'(((start + i) % LW) * 4);
      fill_q.push_back('{addr: wa, data: mem_word(wa), first: (i == 0)});
    end
    if (with_done) line_q.push_back(base);
  endtask

  initial begin : mem_model
    int          rdy_wait;
    int          rsp_wait;
    bit          rsp_pend;
    bit          parity;
    logic [31:0] rsp_addr;
    req_t        r;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    rdy_wait = 0;
    rsp_wait = 0;
    rsp_pend = 1'b0;
    parity   = 1'b0;
    rsp_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (rsp_pend) begin
        if (rsp_wait == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_word(rsp_addr);
          rsp_pend      = 1'b0;
        end else begin
          rsp_wait--;
        end
      end
      parity = ~parity;
      if (!mem_req_valid) begin
        mem_req_ready = 1'b0;
        rdy_wait      = ready_delay;
      end else if (ready_toggle) begin
        mem_req_ready = parity;
      end else if (rdy_wait == 0) begin
        mem_req_ready = 1'b1;
      end else begin
        rdy_wait--;
        mem_req_ready = 1'b0;
      end
      @(negedge clk);
      if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
        total++;
        if (req_q.size() == 0) begin
          $display("FAIL req_unexpected: got we=%0b addr=%h, expected no request", mem_req_we, mem_req_addr);
        end else begin
          r = req_q.pop_front();
          if (mem_req_we !== r.we || mem_req_addr !== r.addr || (r.we && mem_req_wdata !== r.wdata))
            $display("FAIL req_order: got we=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                     mem_req_we, mem_req_addr, mem_req_wdata, r.we, r.addr, r.wdata);
          else
            passed++;
        end
        if (mem_req_we === 1'b1) begin
          wr_hs++;
        end else begin
          rd_hs++;
          rsp_pend = 1'b1;
          rsp_wait = rsp_delay;
          rsp_addr = mem_req_addr;
        end
        rdy_wait = ready_delay;
      end
    end
  end

  initial begin : monitor
    bit          hold;
    bit          crit_ok;
    logic        h_we;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    fill_t       f;
    logic [31:0] la;
    hold    = 1'b0;
    h_we    = 1'b0;
    h_addr  = '0;
    h_wdata = '0;
    forever begin
      @(negedge clk);
      if (hold && rst_n === 1'b1) begin
        total++;
        if (mem_req_valid !== 1'b1 || mem_req_we !== h_we || mem_req_addr !== h_addr || mem_req_wdata !== h_wdata)
          $display("FAIL req_stable: got v=%0b we=%0b addr=%h wdata=%h, expected v=1 we=%0b addr=%h wdata=%h",
                   mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, h_we, h_addr, h_wdata);
        else
          passed++;
      end
      hold    = (rst_n === 1'b1) && (mem_req_valid === 1'b1) && (mem_req_ready !== 1'b1);
      h_we    = mem_req_we;
      h_addr  = mem_req_addr;
      h_wdata = mem_req_wdata;
      if (fill_we === 1'b1) begin
        total++;
        if (fill_q.size() == 0) begin
          $display("FAIL fill_unexpected: got addr=%h data=%h, expected no fill", fill_addr, fill_data);
        end else begin
          f = fill_q.pop_front();
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
          crit_ok = (crit_ready === f.first);
`else
          crit_ok = 1'b1;
`endif
          if (fill_addr !== f.addr || fill_data !== f.data || !crit_ok)
            $display("FAIL fill_word: got addr=%h data=%h crit_ok=%0b, expected addr=%h data=%h first=%0b",
                     fill_addr, fill_data, crit_ok, f.addr, f.data, f.first);
          else
            passed++;
        end
      end
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
      else if (crit_ready !== 1'b0) begin
        total++;
        $display("FAIL crit_spurious: got crit_ready=%0b without fill_we, expected 0", crit_ready);
      end
`endif
      if (fill_done === 1'b1) begin
        done_cnt++;
        total++;
        if (line_q.size() == 0) begin
          $display("FAIL done_unexpected: got fill_done line=%h, expected none", fill_line_addr);
        end else begin
          la = line_q.pop_front();
          if (fill_line_addr !== la)
            $display("FAIL done_line: got %h, expected %h", fill_line_addr, la);
          else
            passed++;
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({stall, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, fill_we, fill_addr,
         fill_data, fill_done, fill_line_addr} !== '0)
      $display("FAIL reset_outputs: got stall=%0b v=%0b addr=%h line=%h, expected all zero",
               stall, mem_req_valid, mem_req_addr, fill_line_addr);
    else
      passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (stall !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL reset_idle: got stall=%0b v=%0b, expected 0 0", stall, mem_req_valid);
    else
      passed++;
  endtask

  task automatic test_basic_miss();
    int n;
    int d0;
    ready_delay = 0; ready_toggle = 1'b0; rsp_delay = 0;
    d0 = done_cnt;
    push_miss(32'h0000_0048, LW, LW, 1'b1);
    @(posedge clk);
    #1;
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0048;
    @(negedge clk);
    total++;
    if (stall !== 1'b1) $display("FAIL basic_stall_comb: got %0b, expected 1", stall);
    else passed++;
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (stall === 1'b1) n++;
      else break;
    end
    total++;
    if (n != 2 * LW + 1) $display("FAIL basic_stall_cycles: got %0d, expected %0d", n, 2 * LW + 1);
    else passed++;
    total++;
    if (done_cnt != d0 + 1 || req_q.size() != 0 || fill_q.size() != 0 || line_q.size() != 0)
      $display("FAIL basic_drain: got done=%0d req=%0d fill=%0d line=%0d left, expected done=%0d and empty",
               done_cnt - d0, req_q.size(), fill_q.size(), line_q.size(), 1);
    else
      passed++;
  endtask

  task automatic test_store_priority();
    int n;
    int w0;
    int d0;
    ready_delay = 3; ready_toggle = 1'b0; rsp_delay = 0;
    w0 = wr_hs;
    d0 = done_cnt;
    req_q.push_back('{we: 1'b1, addr: 32'h0000_0100, wdata: 32'hDEAD_BEEF});
    push_miss(32'h0000_0200, LW, LW, 1'b1);
    @(posedge clk);
    #1;
    wr_req     = 1'b1;
    wr_addr    = 32'h0000_0100;
    wr_data    = 32'hDEAD_BEEF;
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0200;
    @(posedge clk);
    #1;
    wr_req = 1'b0;
    n = 0;
    while (wr_hs == w0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (wr_hs != w0 + 1) $display("FAIL store_handshake: got %0d writes, expected 1", wr_hs - w0);
    else passed++;
    total++;
    if (n < 3) $display("FAIL store_ready_wait: got %0d wait cycles, expected at least 3", n);
    else passed++;
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (done_cnt != d0 + 1 || req_q.size() != 0 || fill_q.size() != 0 || line_q.size() != 0)
      $display("FAIL store_drain: got done=%0d req=%0d fill=%0d line=%0d, expected 1 and empty queues",
               done_cnt - d0, req_q.size(), fill_q.size(), line_q.size());
    else
      passed++;
  endtask

  task automatic test_delayed();
    int n;
    int d0;
    int r0;
    ready_delay = 0; ready_toggle = 1'b1; rsp_delay = 5;
    d0 = done_cnt;
    r0 = rd_hs;
    push_miss(32'h0000_03C4, LW, LW, 1'b1);
    @(posedge clk);
    #1;
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_03C4;
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done_cnt != d0 + 1 || rd_hs != r0 + LW || req_q.size() != 0 || fill_q.size() != 0)
      $display("FAIL delayed_drain: got done=%0d reads=%0d req=%0d fill=%0d, expected 1 %0d 0 0",
               done_cnt - d0, rd_hs - r0, req_q.size(), fill_q.size(), LW);
    else
      passed++;
    ready_toggle = 1'b0;
    rsp_delay    = 0;
  endtask

  task automatic test_reset_mid_refill();
    int n;
    int r0;
    int d0;
    ready_delay = 0; ready_toggle = 1'b0; rsp_delay = 3;
    r0 = rd_hs;
    d0 = done_cnt;
    push_miss(32'h0000_1238, 3, 2, 1'b0);
    @(posedge clk);
    #1;
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_1238;
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
    n = 0;
    while (rd_hs != r0 + 3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (rd_hs != r0 + 3) $display("FAIL rst_reach_beat2: got %0d reads, expected 3", rd_hs - r0);
    else passed++;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({stall, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, fill_we, fill_addr,
         fill_data, fill_done, fill_line_addr} !== '0)
      $display("FAIL rst_async_outputs: got stall=%0b v=%0b addr=%h fill_we=%0b, expected all zero",
               stall, mem_req_valid, mem_req_addr, fill_we);
    else
      passed++;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (fill_we !== 1'b0 || fill_done !== 1'b0 || mem_req_valid !== 1'b0)
        $display("FAIL rst_stale_rsp: got fill_we=%0b fill_done=%0b v=%0b rsp_valid=%0b, expected 0 0 0",
                 fill_we, fill_done, mem_req_valid, mem_rsp_valid);
      else
        passed++;
    end
    total++;
    if (done_cnt != d0 || req_q.size() != 0 || fill_q.size() != 0)
      $display("FAIL rst_partial: got done=%0d req=%0d fill=%0d, expected 0 0 0",
               done_cnt - d0, req_q.size(), fill_q.size());
    else
      passed++;
    rsp_delay = 0;
    push_miss(32'h0000_1238, LW, LW, 1'b1);
    @(posedge clk);
    #1;
    miss_valid = 1'b1;
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (done_cnt != d0 + 1 || req_q.size() != 0 || fill_q.size() != 0 || line_q.size() != 0)
      $display("FAIL rst_recover: got done=%0d req=%0d fill=%0d line=%0d, expected 1 and empty",
               done_cnt - d0, req_q.size(), fill_q.size(), line_q.size());
    else
      passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    int d0;
    ready_delay = 0; ready_toggle = 1'b0; rsp_delay = 0;
    d0 = done_cnt;
    push_miss(32'h0000_0040, LW, LW, 1'b1);
    push_miss(32'h0000_0080, LW, LW, 1'b1);
    @(posedge clk);
    #1;
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0040;
    @(posedge clk);
    #1;
    miss_addr = 32'h0000_0080;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    total++;
    if (stall !== 1'b1 || mem_req_valid !== 1'b0)
      $display("FAIL b2b_idle_cycle: got stall=%0b v=%0b, expected 1 0", stall, mem_req_valid);
    else
      passed++;
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
    @(negedge clk);
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0080)
      $display("FAIL b2b_second_start: got v=%0b addr=%h, expected 1 00000080", mem_req_valid, mem_req_addr);
    else
      passed++;
    n = 0;
    while (done_cnt != d0 + 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (done_cnt != d0 + 2 || req_q.size() != 0 || fill_q.size() != 0 || line_q.size() != 0)
      $display("FAIL b2b_drain: got done=%0d req=%0d fill=%0d line=%0d, expected 2 and empty",
               done_cnt - d0, req_q.size(), fill_q.size(), line_q.size());
    else
      passed++;
  endtask

  initial begin
    rst_n      = 1'b0;
    miss_valid = 1'b0;
    miss_addr  = '0;
    wr_req     = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    test_reset();
    test_basic_miss();
    test_store_priority();
    test_delayed();
    test_reset_mid_refill();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
